// File: rtl/alu_pkg.sv
// Shared constants for the registered ALU: default datapath width and the 4-bit opcode map.
package alu_pkg;
   localparam int DEF_WIDTH = 8;

   localparam logic [3:0] OP_ADD  = 4'd0;
   localparam logic [3:0] OP_SUB  = 4'd1;
   localparam logic [3:0] OP_MUL  = 4'd2;
   localparam logic [3:0] OP_DIV  = 4'd3;
   localparam logic [3:0] OP_SHL  = 4'd4;
   localparam logic [3:0] OP_SHR  = 4'd5;
   localparam logic [3:0] OP_ROL  = 4'd6;
   localparam logic [3:0] OP_ROR  = 4'd7;
   localparam logic [3:0] OP_AND  = 4'd8;
   localparam logic [3:0] OP_OR   = 4'd9;
   localparam logic [3:0] OP_XOR  = 4'd10;
   localparam logic [3:0] OP_NOR  = 4'd11;
   localparam logic [3:0] OP_NAND = 4'd12;
   localparam logic [3:0] OP_XNOR = 4'd13;
   localparam logic [3:0] OP_GT   = 4'd14;
   localparam logic [3:0] OP_EQ   = 4'd15;
endpackage

// File: rtl/alu_if.sv
// Operand/opcode/result bundle for alu_8bit. Zero exists only when ALU_ZERO_FLAG_EN is defined.
interface alu_if
   import alu_pkg::*;
#(
   parameter int WIDTH = DEF_WIDTH
);
   logic [WIDTH-1:0] A;
   logic [WIDTH-1:0] B;
   logic [3:0]       ALU_Sel;
   logic [WIDTH-1:0] ALU_Out;
   logic             CarryOut;
`ifdef ALU_ZERO_FLAG_EN
   logic             Zero;

   modport master (output A, B, ALU_Sel, input ALU_Out, CarryOut, Zero);
   modport slave  (input A, B, ALU_Sel, output ALU_Out, CarryOut, Zero);
`else
   modport master (output A, B, ALU_Sel, input ALU_Out, CarryOut);
   modport slave  (input A, B, ALU_Sel, output ALU_Out, CarryOut);
`endif
endinterface

// File: rtl/alu_comb.sv
// Purely combinational ALU function: {out, carry} = f(a, b, sel) for all 16 opcodes.
module alu_comb
   import alu_pkg::*;
#(
   parameter int WIDTH = DEF_WIDTH
) (
   input  logic [WIDTH-1:0] a_i,
   input  logic [WIDTH-1:0] b_i,
   input  logic [3:0]       sel_i,
   output logic [WIDTH-1:0] out_o,
   output logic             carry_o
);
   logic [WIDTH:0]     sum;
   logic [WIDTH:0]     diff;
   logic [2*WIDTH-1:0] prod;

   assign sum  = {1'b0, a_i} + {1'b0, b_i};
   // Top bit of the widened difference is the borrow (set exactly when a < b).
   assign diff = {1'b0, a_i} - {1'b0, b_i};
   assign prod = (2*WIDTH)'(a_i) * (2*WIDTH)'(b_i);

   always_comb begin
      out_o   = '0;
      carry_o = 1'b0;
      case (sel_i)
         OP_ADD:  begin out_o = sum[WIDTH-1:0];  carry_o = sum[WIDTH];  end
         OP_SUB:  begin out_o = diff[WIDTH-1:0]; carry_o = diff[WIDTH]; end
         OP_MUL:  begin out_o = prod[WIDTH-1:0]; carry_o = |prod[2*WIDTH-1:WIDTH]; end
         OP_DIV: begin
            if (b_i == '0) begin
               out_o   = '1;
               carry_o = 1'b1;
            end else begin
               out_o = a_i / b_i;
            end
         end
         OP_SHL:  begin out_o = {a_i[WIDTH-2:0], 1'b0}; carry_o = a_i[WIDTH-1]; end
         OP_SHR:  begin out_o = {1'b0, a_i[WIDTH-1:1]}; carry_o = a_i[0];       end
         OP_ROL:  out_o = {a_i[WIDTH-2:0], a_i[WIDTH-1]};
         OP_ROR:  out_o = {a_i[0], a_i[WIDTH-1:1]};
         OP_AND:  out_o = a_i & b_i;
         OP_OR:   out_o = a_i | b_i;
         OP_XOR:  out_o = a_i ^ b_i;
         OP_NOR:  out_o = ~(a_i | b_i);
         OP_NAND: out_o = ~(a_i & b_i);
         OP_XNOR: out_o = ~(a_i ^ b_i);
         OP_GT:   out_o = WIDTH'(a_i > b_i);
         OP_EQ:   out_o = WIDTH'(a_i == b_i);
         default: begin out_o = '0; carry_o = 1'b0; end
      endcase
   end
endmodule

// File: rtl/alu_8bit.sv
// Registered ALU: one-cycle latency, one op per clock, async active-low reset.
// Optional Zero flag built when ALU_ZERO_FLAG_EN is defined.
module alu_8bit
   import alu_pkg::*;
#(
   parameter int WIDTH = DEF_WIDTH
) (
   input  logic  clk,
   input  logic  rst_n,
   alu_if.slave  bus
);
   logic [WIDTH-1:0] out_d, out_q;
   logic             carry_d, carry_q;

   alu_comb #(.WIDTH(WIDTH)) u_comb (
      .a_i     (bus.A),
      .b_i     (bus.B),
      .sel_i   (bus.ALU_Sel),
      .out_o   (out_d),
      .carry_o (carry_d)
   );

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         out_q   <= '0;
         carry_q <= 1'b0;
      end else begin
         out_q   <= out_d;
         carry_q <= carry_d;
      end
   end

   assign bus.ALU_Out  = out_q;
   assign bus.CarryOut = carry_q;

`ifdef ALU_ZERO_FLAG_EN
   logic zero_d, zero_q;

   assign zero_d = (out_d == '0);

   // Resets high so it agrees with the reset value of ALU_Out.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) zero_q <= 1'b1;
      else        zero_q <= zero_d;
   end

   assign bus.Zero = zero_q;
`else
   // No Zero flag in this build; result and carry only.
`endif
endmodule

// File: tb/tb_alu_8bit.sv
// Self-checking bench for alu_8bit: directed cases plus a random sweep against an integer model.
module tb_alu_8bit;
   logic clk = 1'b0;
   logic rst_n = 1'b1;
   int   n_checks = 0;
   int   n_fail   = 0;

   alu_if #(.WIDTH(8)) bus ();

   alu_8bit #(.WIDTH(8)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   always #5 clk = ~clk;

   // Reference: plain integer arithmetic from the opcode table, returns {carry, out}.
   function automatic logic [8:0] model(input int op, input int a, input int b);
      int r;
      int c;
      r = 0;
      c = 0;
      case (op)
         0:  begin r = a + b; c = (r > 255); end
         1:  begin r = a - b; c = (a < b); end
         2:  begin r = a * b; c = (r > 255); end
         3:  begin if (b == 0) begin r = 255; c = 1; end else r = a / b; end
         4:  begin r = a * 2; c = (a >= 128); end
         5:  begin r = a / 2; c = a % 2; end
         6:  r = a * 2 + a / 128;
         7:  r = a / 2 + (a % 2) * 128;
         8:  r = a & b;
         9:  r = a | b;
         10: r = a ^ b;
         11: r = ~(a | b);
         12: r = ~(a & b);
         13: r = ~(a ^ b);
         14: r = (a > b) ? 1 : 0;
         15: r = (a == b) ? 1 : 0;
         default: r = 0;
      endcase
      return {c[0], 8'(r & 255)};
   endfunction

   task automatic drive(input logic [7:0] a, input logic [7:0] b, input logic [3:0] op);
      bus.A = a;
      bus.B = b;
      bus.ALU_Sel = op;
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset();
      drive(8'($urandom), 8'($urandom), 4'($urandom));
      #1 rst_n = 1'b0;
      #1;
      n_checks++;
      if (bus.ALU_Out !== 8'h00 || bus.CarryOut !== 1'b0) begin
         n_fail++;
         $display("FAIL reset_async: out=%h carry=%b, required out=00 carry=0", bus.ALU_Out, bus.CarryOut);
      end
`ifdef ALU_ZERO_FLAG_EN
      n_checks++;
      if (bus.Zero !== 1'b1) begin
         n_fail++;
         $display("FAIL reset_zero: zero=%b, required 1", bus.Zero);
      end
`endif
      step();
      n_checks++;
      if (bus.ALU_Out !== 8'h00 || bus.CarryOut !== 1'b0) begin
         n_fail++;
         $display("FAIL reset_hold: out=%h carry=%b, required out=00 carry=0", bus.ALU_Out, bus.CarryOut);
      end
      rst_n = 1'b1;
   endtask

   task automatic test_add();
      drive(8'hC8, 8'h64, 4'd0);
      step();
      n_checks++;
      if (bus.ALU_Out !== 8'h2C || bus.CarryOut !== 1'b1) begin
         n_fail++;
         $display("FAIL add_carry: out=%h carry=%b, required out=2c carry=1", bus.ALU_Out, bus.CarryOut);
      end
      drive(8'd3, 8'd4, 4'd0);
      step();
      n_checks++;
      if (bus.ALU_Out !== 8'd7 || bus.CarryOut !== 1'b0) begin
         n_fail++;
         $display("FAIL add_small: out=%h carry=%b, required out=07 carry=0", bus.ALU_Out, bus.CarryOut);
      end
      drive(8'hFF, 8'h01, 4'd0);
      step();
      n_checks++;
      if (bus.ALU_Out !== 8'h00 || bus.CarryOut !== 1'b1) begin
         n_fail++;
         $display("FAIL add_wrap: out=%h carry=%b, required out=00 carry=1", bus.ALU_Out, bus.CarryOut);
      end
   endtask

   task automatic test_mul();
      drive(8'h10, 8'h11, 4'd2);
      step();
      n_checks++;
      if (bus.ALU_Out !== 8'h10 || bus.CarryOut !== 1'b1) begin
         n_fail++;
         $display("FAIL mul_ovf: out=%h carry=%b, required out=10 carry=1", bus.ALU_Out, bus.CarryOut);
      end
      drive(8'd5, 8'd6, 4'd2);
      step();
      n_checks++;
      if (bus.ALU_Out !== 8'd30 || bus.CarryOut !== 1'b0) begin
         n_fail++;
         $display("FAIL mul_small: out=%h carry=%b, required out=1e carry=0", bus.ALU_Out, bus.CarryOut);
      end
   endtask

   task automatic test_sub_div();
      drive(8'd2, 8'd5, 4'd1);
      step();
      n_checks++;
      if (bus.ALU_Out !== 8'hFD || bus.CarryOut !== 1'b1) begin
         n_fail++;
         $display("FAIL sub_borrow: out=%h carry=%b, required out=fd carry=1", bus.ALU_Out, bus.CarryOut);
      end
      drive(8'd0, 8'd1, 4'd1);
      step();
      n_checks++;
      if (bus.ALU_Out !== 8'hFF || bus.CarryOut !== 1'b1) begin
         n_fail++;
         $display("FAIL sub_wrap: out=%h carry=%b, required out=ff carry=1", bus.ALU_Out, bus.CarryOut);
      end
      drive(8'd100, 8'd7, 4'd3);
      step();
      n_checks++;
      if (bus.ALU_Out !== 8'd14 || bus.CarryOut !== 1'b0) begin
         n_fail++;
         $display("FAIL div: out=%h carry=%b, required out=0e carry=0", bus.ALU_Out, bus.CarryOut);
      end
      drive(8'd100, 8'd0, 4'd3);
      step();
      n_checks++;
      if (bus.ALU_Out !== 8'hFF || bus.CarryOut !== 1'b1) begin
         n_fail++;
         $display("FAIL div_zero: out=%h carry=%b, required out=ff carry=1", bus.ALU_Out, bus.CarryOut);
      end
   endtask

   task automatic test_shift_logic();
      drive(8'h81, 8'h00, 4'd4);
      step();
      n_checks++;
      if (bus.ALU_Out !== 8'h02 || bus.CarryOut !== 1'b1) begin
         n_fail++;
         $display("FAIL shl: out=%h carry=%b, required out=02 carry=1", bus.ALU_Out, bus.CarryOut);
      end
      drive(8'h81, 8'h00, 4'd7);
      step();
      n_checks++;
      if (bus.ALU_Out !== 8'hC0 || bus.CarryOut !== 1'b0) begin
         n_fail++;
         $display("FAIL ror: out=%h carry=%b, required out=c0 carry=0", bus.ALU_Out, bus.CarryOut);
      end
      drive(8'hF0, 8'h3C, 4'd10);
      step();
      n_checks++;
      if (bus.ALU_Out !== 8'hCC || bus.CarryOut !== 1'b0) begin
         n_fail++;
         $display("FAIL xor: out=%h carry=%b, required out=cc carry=0", bus.ALU_Out, bus.CarryOut);
      end
      drive(8'hF0, 8'h3C, 4'd12);
      step();
      n_checks++;
      if (bus.ALU_Out !== 8'hCF || bus.CarryOut !== 1'b0) begin
         n_fail++;
         $display("FAIL nand: out=%h carry=%b, required out=cf carry=0", bus.ALU_Out, bus.CarryOut);
      end
   endtask

   // Mid-stream reset drops the pending result; first edge after release loads live inputs.
   task automatic test_reset_midstream();
      drive(8'hC8, 8'h64, 4'd0);
      step();
      drive(8'($urandom), 8'($urandom), 4'($urandom));
      #2 rst_n = 1'b0;
      #1;
      n_checks++;
      if (bus.ALU_Out !== 8'h00 || bus.CarryOut !== 1'b0) begin
         n_fail++;
         $display("FAIL reset_mid: out=%h carry=%b, required out=00 carry=0", bus.ALU_Out, bus.CarryOut);
      end
      step();
      drive(8'd3, 8'd4, 4'd0);
      #2 rst_n = 1'b1;
      step();
      n_checks++;
      if (bus.ALU_Out !== 8'd7 || bus.CarryOut !== 1'b0) begin
         n_fail++;
         $display("FAIL reset_release: out=%h carry=%b, required out=07 carry=0", bus.ALU_Out, bus.CarryOut);
      end
   endtask

   // Back-to-back random ops; output must hold the previous result until the next edge.
   task automatic test_random();
      logic [8:0] exp;
      logic [8:0] prev;
      logic [7:0] a, b;
      logic [3:0] op;
      prev = {bus.CarryOut, bus.ALU_Out};
      for (int i = 0; i < 400; i++) begin
         a  = 8'($urandom);
         b  = (i % 13 == 0) ? 8'd0 : 8'($urandom);
         op = 4'(i % 16);
         if (i % 3 == 0) op = 4'($urandom);
         drive(a, b, op);
         #1;
         n_checks++;
         if ({bus.CarryOut, bus.ALU_Out} !== prev) begin
            n_fail++;
            $display("FAIL latency_hold[%0d]: got %h, required %h", i, {bus.CarryOut, bus.ALU_Out}, prev);
         end
         exp = model(int'(op), int'(a), int'(b));
         @(posedge clk);
         #1;
         n_checks++;
         if ({bus.CarryOut, bus.ALU_Out} !== exp) begin
            n_fail++;
            $display("FAIL random[%0d] op=%0d a=%h b=%h: carry/out=%h, required %h",
                     i, op, a, b, {bus.CarryOut, bus.ALU_Out}, exp);
         end
`ifdef ALU_ZERO_FLAG_EN
         n_checks++;
         if (bus.Zero !== (exp[7:0] == 8'h00)) begin
            n_fail++;
            $display("FAIL random_zero[%0d]: zero=%b, required %b", i, bus.Zero, exp[7:0] == 8'h00);
         end
`endif
         prev = exp;
      end
   endtask

   task automatic test_zero_xor();
      logic [7:0] a;
      a = 8'($urandom);
      drive(a, a, 4'd10);
      step();
      n_checks++;
      if (bus.ALU_Out !== 8'h00 || bus.CarryOut !== 1'b0) begin
         n_fail++;
         $display("FAIL xor_self: out=%h carry=%b, required out=00 carry=0", bus.ALU_Out, bus.CarryOut);
      end
`ifdef ALU_ZERO_FLAG_EN
      n_checks++;
      if (bus.Zero !== 1'b1) begin
         n_fail++;
         $display("FAIL zero_set: zero=%b, required 1", bus.Zero);
      end
      drive(a, ~a, 4'd10);
      step();
      n_checks++;
      if (bus.Zero !== 1'b0) begin
         n_fail++;
         $display("FAIL zero_clear: zero=%b, required 0", bus.Zero);
      end
`endif
   endtask

   initial begin
      drive(8'h00, 8'h00, 4'd0);
      test_reset();
      test_add();
      test_mul();
      test_sub_div();
      test_shift_logic();
      test_reset_midstream();
      test_random();
      test_zero_xor();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end
endmodule
